// File: rtl/channel_readout_sequencer.sv
// Event readout sequencer: on a trigger edge, waits for the enabled digitizer slices,
// emits a header word, then streams how_many samples per enabled channel in ascending order.
module channel_readout_sequencer #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 12,
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trigger,
    input  logic [11:0]              how_many,
    input  logic [11:0]              offset,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [N_CH-1:0]          ch_data_ready,
    input  logic [N_CH*DATA_W-1:0]   ch_data_in,
    output logic [N_CH-1:0]          ch_read_request,
    output logic [11:0]              ch_how_many,
    output logic [11:0]              ch_offset,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               missed_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_HEADER, S_REQ, S_WAIT_DATA, S_PRESENT, S_DONE
    } state_e;

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = 3;

    state_e             state_q, state_d;
    logic               trig_q;
    logic [11:0]        how_many_q, how_many_d;
    logic [11:0]        offset_q, offset_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic               err_q, err_d;
    logic [11:0]        evt_cnt_q, evt_cnt_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [3:0]         cur_ch_q, cur_ch_d;
    logic [11:0]        smp_cnt_q, smp_cnt_d;
    logic [11:0]        sample_q, sample_d;
    logic [7:0]         missed_q, missed_d;

    logic               trig_edge;
    logic               hdr_last;
    logic               more_smp;
    logic               smp_last;
    logic [4:0]         first_ch;
    logic [4:0]         next_ch;
    logic [DATA_W-1:0]  sample_sel;

    // Returns {found, index} of the lowest enabled channel at or above start.
    function automatic logic [4:0] find_ch(input logic [N_CH-1:0] mask, input int start);
        logic [4:0] r;
        r = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k] && k >= start) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction

    assign trig_edge = trigger & ~trig_q;
    assign hdr_last  = err_q | (mask_q == '0) | (how_many_q == '0);
    assign first_ch  = find_ch(mask_q, 0);
    assign next_ch   = find_ch(mask_q, int'(cur_ch_q) + 1);
    assign more_smp  = (smp_cnt_q + 12'd1) < how_many_q;
    assign smp_last  = ~more_smp & ~next_ch[4];

    always_comb begin
        sample_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch_q == 4'(k)) sample_sel = ch_data_in[k*DATA_W +: DATA_W];
        end
    end

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        how_many_d = how_many_q;
        offset_d   = offset_q;
        mask_d     = mask_q;
        err_d      = err_q;
        evt_cnt_d  = evt_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        cur_ch_d   = cur_ch_q;
        smp_cnt_d  = smp_cnt_q;
        sample_d   = sample_q;
        missed_d   = missed_q;

        if (trig_edge && state_q != S_IDLE && missed_q != 8'hFF) missed_d = missed_q + 8'd1;

        unique case (state_q)
            S_IDLE: begin
                if (trig_edge) begin
                    how_many_d = how_many;
                    offset_d   = offset;
                    mask_d     = ch_mask;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if ((ch_data_ready & mask_q) == mask_q) begin
                    state_d = S_HEADER;
                end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HEADER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_HEADER: begin
                if (out_ready) begin
                    evt_cnt_d = evt_cnt_q + 12'd1;
                    cur_ch_d  = first_ch[3:0];
                    smp_cnt_d = '0;
                    state_d   = hdr_last ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                lat_cnt_d = '0;
                state_d   = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (lat_cnt_q == LAT_W'(READ_LAT - 1)) begin
                    sample_d = 12'(sample_sel);
                    state_d  = S_PRESENT;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (more_smp) begin
                        smp_cnt_d = smp_cnt_q + 12'd1;
                        state_d   = S_REQ;
                    end else if (next_ch[4]) begin
                        cur_ch_d  = next_ch[3:0];
                        smp_cnt_d = '0;
                        state_d   = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            how_many_q <= '0;
            offset_q   <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
            evt_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            cur_ch_q   <= '0;
            smp_cnt_q  <= '0;
            sample_q   <= '0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            how_many_q <= how_many_d;
            offset_q   <= offset_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            evt_cnt_q  <= evt_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            cur_ch_q   <= cur_ch_d;
            smp_cnt_q  <= smp_cnt_d;
            sample_q   <= sample_d;
            missed_q   <= missed_d;
        end
    end

    always_comb begin
        ch_read_request = '0;
        out_data        = '0;
        out_valid       = 1'b0;
        out_last        = 1'b0;
        done            = 1'b0;
        busy            = (state_q != S_IDLE) && (state_q != S_DONE);
        unique case (state_q)
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = {(err_q ? 4'hE : 4'hA), evt_cnt_q};
                out_last  = hdr_last;
            end
            S_REQ: begin
                for (int k = 0; k < N_CH; k++) ch_read_request[k] = (cur_ch_q == 4'(k));
            end
            S_PRESENT: begin
                out_valid = 1'b1;
                out_data  = {cur_ch_q, sample_q};
                out_last  = smp_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign ch_how_many = how_many_q;
    assign ch_offset   = offset_q;
    assign missed_cnt  = missed_q;

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// Directed bench for channel_readout_sequencer: a behavioural channel model answers each
// request READ_LAT cycles later with a numbered sample; the stream is compared to fixed words.
module tb_channel_readout_sequencer;

    localparam int N_CH     = 4;
    localparam int DATA_W   = 12;
    localparam int READ_LAT = 2;

    logic                    clk;
    logic                    reset;
    logic                    trigger;
    logic [11:0]             how_many;
    logic [11:0]             offset;
    logic [N_CH-1:0]         ch_mask;
    logic [N_CH-1:0]         ch_data_ready;
    logic [N_CH*DATA_W-1:0]  ch_data_in;
    logic [N_CH-1:0]         ch_read_request;
    logic [11:0]             ch_how_many;
    logic [11:0]             ch_offset;
    logic [15:0]             out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic [7:0]              missed_cnt;

    channel_readout_sequencer #(
        .N_CH(N_CH), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .TIMEOUT(1023)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .how_many(how_many), .offset(offset),
        .ch_mask(ch_mask), .ch_data_ready(ch_data_ready), .ch_data_in(ch_data_in),
        .ch_read_request(ch_read_request), .ch_how_many(ch_how_many), .ch_offset(ch_offset),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .missed_cnt(missed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] ch;
        logic [11:0] val;
    } rq_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] words[$];
    logic [16:0] exp_w[$];
    int          req_cnt, done_cnt, onehot_err, stall_err, offset_err, valid_cnt;
    int          seq = 0;
    logic [11:0] exp_offset = '0;
    logic        chk_offset = 1'b0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word  = '0;
    rq_t         hist [0:READ_LAT];

    // Monitor and channel model, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset && prev_stall && (!out_valid || {out_last, out_data} !== prev_word)) stall_err++;
        prev_stall = reset && out_valid && !out_ready;
        prev_word  = {out_last, out_data};
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready) words.push_back({out_last, out_data});
        if (done) done_cnt++;
        if (!$onehot0(ch_read_request)) onehot_err++;
        if (busy && chk_offset && ch_offset !== exp_offset) offset_err++;

        for (int i = READ_LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '0;
        if (|ch_read_request) begin
            req_cnt++;
            hist[0].v = 1'b1;
            for (int k = 0; k < N_CH; k++) if (ch_read_request[k]) hist[0].ch = 4'(k);
            hist[0].val = 12'h500 + 12'(seq);
            seq++;
        end
        for (int k = 0; k < N_CH; k++) ch_data_in[k*DATA_W +: DATA_W] = 12'hEEE;
        if (hist[READ_LAT].v) ch_data_in[int'(hist[READ_LAT].ch)*DATA_W +: DATA_W] = hist[READ_LAT].val;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words.delete();
        exp_w.delete();
        req_cnt = 0; done_cnt = 0; onehot_err = 0; stall_err = 0; offset_err = 0; valid_cnt = 0;
    endtask

    task automatic start_event(input logic [11:0] hm, input logic [11:0] off, input logic [N_CH-1:0] mask);
        clear_mon();
        how_many   = hm;
        offset     = off;
        ch_mask    = mask;
        exp_offset = off;
        chk_offset = 1'b0;
        trigger    = 1'b1;
    endtask

    task automatic run_to_done(input string tag, input int budget, input logic rnd, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            trigger    = 1'b0;
            chk_offset = 1'b1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (done) break;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        tick();
        out_ready = 1'b1;
    endtask

    task automatic check_words(input string tag);
        check({tag, "_nwords"}, 32'(words.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < words.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 32'(words[i]), 32'(exp_w[i]));
    endtask

    int cyc;
    logic found;

    initial begin
        for (int i = 0; i <= READ_LAT; i++) hist[i] = '0;
        clear_mon();
        reset = 1'b0; trigger = 1'b0; how_many = '0; offset = '0; ch_mask = '0;
        ch_data_ready = '0; out_ready = 1'b0;

        // Reset
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_req", 32'(ch_read_request), 0);
        check("rst_missed", 32'(missed_cnt), 0);
        check("rst_how_many", 32'(ch_how_many), 0);
        check("rst_offset", 32'(ch_offset), 0);
        reset = 1'b1;
        tick();

        // Two channels, two samples each
        ch_data_ready = 4'hF;
        out_ready     = 1'b1;
        start_event(12'd2, 12'd5, 4'b0101);
        run_to_done("ev1", 100, 1'b0, cyc);
        exp_w = '{17'h0_A000, 17'h0_0500, 17'h0_0501, 17'h0_2502, 17'h1_2503};
        check_words("ev1");
        check("ev1_reqs", 32'(req_cnt), 4);
        check("ev1_onehot", 32'(onehot_err), 0);
        check("ev1_done_pulses", 32'(done_cnt), 1);
        check("ev1_offset_held", 32'(offset_err), 0);
        check("ev1_ch_offset", 32'(ch_offset), 5);
        check("ev1_ch_how_many", 32'(ch_how_many), 2);

        // how_many = 0: header only
        start_event(12'd0, 12'd7, 4'hF);
        run_to_done("ev2", 100, 1'b0, cyc);
        exp_w = '{17'h1_A001};
        check_words("ev2");
        check("ev2_reqs", 32'(req_cnt), 0);
        check("ev2_done_pulses", 32'(done_cnt), 1);

        // Channel 1 never ready: timeout header
        ch_data_ready = 4'b1101;
        start_event(12'd2, 12'd3, 4'b0010);
        run_to_done("ev3", 1200, 1'b0, cyc);
        check("ev3_cycles", 32'(cyc), 1025);
        exp_w = '{17'h1_E002};
        check_words("ev3");
        check("ev3_reqs", 32'(req_cnt), 0);
        check("ev3_done_pulses", 32'(done_cnt), 1);
        ch_data_ready = 4'hF;

        // Random back-pressure on channel 3
        start_event(12'd3, 12'h123, 4'b1000);
        run_to_done("ev4", 300, 1'b1, cyc);
        exp_w = '{17'h0_A003, 17'h0_3504, 17'h0_3505, 17'h1_3506};
        check_words("ev4");
        check("ev4_stall_stable", 32'(stall_err), 0);
        check("ev4_reqs", 32'(req_cnt), 3);
        check("ev4_done_pulses", 32'(done_cnt), 1);
        check("ev4_offset_held", 32'(offset_err), 0);

        // Missed trigger, then reset while a sample is stalled
        out_ready = 1'b0;
        start_event(12'd4, 12'd9, 4'b0001);
        tick(); trigger = 1'b0; chk_offset = 1'b1;
        tick(); trigger = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            out_ready = out_valid && (out_data[15:12] == 4'hA);
            if (out_valid && out_data[15:12] == 4'h0) found = 1'b1;
        end
        check("ev5_present_seen", 32'(found), 1);
        check("ev5_missed", 32'(missed_cnt), 1);
        check("ev5_sample", 32'(out_data), 32'h0507);
        check("ev5_busy", 32'(busy), 1);
        reset = 1'b0; trigger = 1'b0;
        tick();
        check("ev5_rst_valid", 32'(out_valid), 0);
        check("ev5_rst_busy", 32'(busy), 0);
        check("ev5_rst_missed", 32'(missed_cnt), 0);
        check("ev5_rst_how_many", 32'(ch_how_many), 0);
        check("ev5_rst_offset", 32'(ch_offset), 0);
        reset = 1'b1;
        clear_mon();
        out_ready = 1'b1;
        repeat (20) tick();
        check("ev5_post_valid", 32'(valid_cnt), 0);
        check("ev5_post_words", 32'(words.size()), 0);
        check("ev5_post_reqs", 32'(req_cnt), 0);
        check("ev5_post_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_readout_sequencer.md
Name: channel_readout_sequencer

Overview:
- Sequences event readout across N_CH single-channel digitizer slices sharing one output stream.
- On a trigger rising edge it latches the readout window (how_many, offset, channel mask) and waits for all enabled channels to report data ready.
- It then emits a header word and requests how_many samples from each enabled channel in ascending channel order.
- It packs every returned sample into a 16-bit valid/ready stream for the downstream event builder / USB FIFO.

Parameters:
- N_CH, 4, number of channel slices (1..16).
- DATA_W, 12, sample width per channel.
- READ_LAT, 2, cycles from ch_read_request to the sample appearing on ch_data_in (1..7).
- TIMEOUT, 1023, maximum cycles to wait for ch_data_ready before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- trigger  in  1  event trigger, level; rising edge detected internally.
- how_many  in  12  samples per channel; latched at trigger.
- offset  in  12  start offset into channel buffer; latched at trigger.
- ch_mask  in  N_CH  channel enable; latched at trigger.
- ch_data_ready  in  N_CH  per-channel buffer-filled flag.
- ch_data_in  in  N_CH*DATA_W  per-channel sample bus; slice k = bits [k*12+11:k*12].
- ch_read_request  out  N_CH  one-hot, one-cycle sample request.
- ch_how_many  out  12  latched how_many, broadcast to all channels.
- ch_offset  out  12  latched offset, broadcast to all channels.
- out_data  out  16  stream word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  final word of the event.
- busy  out  1  high from trigger acceptance until the DONE cycle.
- done  out  1  one-cycle pulse at end of event.
- missed_cnt  out  8  triggers ignored while busy; saturating.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, state IDLE, trigger edge register cleared, event counter cleared. Takes effect mid-event: the partial event is dropped and nothing further is emitted.
- Trigger edge: trig_q <= trigger; an edge is trigger & ~trig_q.
  - Edge in IDLE at cycle t: latch how_many, offset, ch_mask; busy=1 and state WAIT_RDY at t+1.
  - Edge while busy: ignored; missed_cnt increments, saturating at 255.
- States: IDLE, WAIT_RDY, HEADER, REQ, WAIT_DATA, PRESENT, DONE.
- WAIT_RDY:
  - Proceeds to HEADER when (ch_data_ready & mask) == mask. An all-zero mask passes immediately.
  - A cycle counter runs; at TIMEOUT cycles it sets the error flag and goes to HEADER.
- HEADER:
  - out_valid=1, out_data = {4'hA, evt_cnt[11:0]}, or {4'hE, evt_cnt} on timeout.
  - out_last=1 if error, mask==0, or how_many==0.
  - Holds until out_ready. On accept, evt_cnt increments (wraps at 4095).
  - Next state: DONE if out_last was set, else REQ for the lowest enabled channel.
- REQ: ch_read_request[k]=1 for exactly one cycle; next state WAIT_DATA.
- WAIT_DATA: counts READ_LAT-1 cycles. Slice k is captured at the edge READ_LAT cycles after the REQ cycle; next state PRESENT.
- PRESENT:
  - out_valid=1, out_data = {ch_id[3:0], sample[11:0]}.
  - out_last=1 on the last sample of the last enabled channel.
  - Holds stable until out_ready. On accept: sample_cnt+1 < how_many → REQ same channel; else advance to the next higher enabled channel and REQ; else DONE.
- DONE: done=1 for one cycle, busy=0, error flag cleared, then IDLE. A trigger edge in the DONE cycle is counted as missed.
- ch_how_many / ch_offset: hold latched values from acceptance until the next acceptance; 0 after reset.
- Stream rules: out_data and out_last stay constant while out_valid & ~out_ready. At most one outstanding request exists at a time.
- Sample counter is 12 bits; how_many=4095 yields 4095 samples per channel.

Test Plan:
- Reset=0 for 2 cycles, then release → all outputs 0, missed_cnt=0, busy=0.
- mask=4'b0101, how_many=2, offset=5, all ready, out_ready=1 → words A000, 0xxx, 0xxx, 2xxx, 2xxx; last on the 5th word; each sample equals the slice value driven READ_LAT cycles after its request; ch_offset=5 throughout; done pulses once.
- how_many=0, mask=4'hF → single word A001 with out_last=1, no ch_read_request, done.
- ch_data_ready[1] stuck at 0, mask=4'h2 → after 1023 cycles, word E00n with last=1; no requests issued.
- out_ready toggled randomly, 3 samples on channel 3 → out_data and out_last stable while stalled; no word lost or duplicated.
- Second trigger during event, then reset=0 mid-PRESENT → missed_cnt=1 before reset; after reset, outputs 0 and no further words.
